// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and entry slicing for the matrix result path.
package matrix_pkg;

    localparam int unsigned DIM       = 4;
    localparam int unsigned ENTRY_W   = 6;
    localparam int unsigned FIELD_W   = 3;
    localparam int unsigned N_ENTRIES = DIM * DIM;
    localparam int unsigned RESULT_W  = N_ENTRIES * ENTRY_W;
    localparam int unsigned IDX_W     = $clog2(N_ENTRIES);
    localparam int unsigned DIM_W     = $clog2(DIM);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } stream_state_t;

    // Entry k is stored row-major starting at the MSB end of the packed word.
    function automatic logic [ENTRY_W-1:0] entry_of(input logic [RESULT_W-1:0] word,
                                                    input logic [IDX_W-1:0]    k);
        logic [RESULT_W-1:0] shifted;
        shifted = word >> ((N_ENTRIES - 1 - int'(k)) * ENTRY_W);
        return shifted[ENTRY_W-1:0];
    endfunction

endpackage

// File: rtl/result_entry_mux.sv
// Selects one entry of the captured result word and optionally sign-extends
// the adder result field for subtraction results.
module result_entry_mux
    import matrix_pkg::*;
(
    input  logic [RESULT_W-1:0] word,
    input  logic [IDX_W-1:0]    idx,
    input  logic                sub_mode,
    output logic [ENTRY_W-1:0]  data
);

    logic [ENTRY_W-1:0] raw;

    // Slice the addressed entry, then widen the low field's sign for subtraction.
    always_comb begin
        raw = entry_of(word, idx);
        if (sub_mode) begin
            data = {{(ENTRY_W - FIELD_W){raw[FIELD_W-1]}}, raw[FIELD_W-1:0]};
        end else begin
            data = raw;
        end
    end

endmodule

// File: rtl/mat_result_streamer.sv
// Captures the 4x4 matrix result on the rising edge of the upstream finish level
// and streams its 16 entries over a valid/ready interface with row/col/last tags.
module mat_result_streamer
    import matrix_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [RESULT_W-1:0] mat_in,
    input  logic                res_valid,
    input  logic                sub_mode,
    output logic [ENTRY_W-1:0]  out_data,
    output logic [DIM_W-1:0]    out_row,
    output logic [DIM_W-1:0]    out_col,
    output logic                out_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                done
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ENTRIES - 1);

    stream_state_t       state;
    logic                res_valid_q;
    logic                rise;
    logic [IDX_W-1:0]    count;
    logic [RESULT_W-1:0] cap_word;
    logic                cap_sub;
    logic [ENTRY_W-1:0]  mux_data;
    logic                at_last;

    assign rise    = res_valid & ~res_valid_q;
    assign at_last = (count == LAST_IDX);

    // Previous-cycle copy of the finish level, tracked in every state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_valid_q <= 1'b0;
        end else begin
            res_valid_q <= res_valid;
        end
    end

    // Capture / stream / done sequencer with registered valid, busy and done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            cap_word  <= '0;
            cap_sub   <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (rise) begin
                        cap_word  <= mat_in;
                        cap_sub   <= sub_mode;
                        count     <= '0;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= STREAM;
                    end
                end
                STREAM: begin
                    if (out_valid && out_ready) begin
                        count <= count + 1'b1;
                        if (at_last) begin
                            out_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    result_entry_mux u_mux (
        .word     (cap_word),
        .idx      (count),
        .sub_mode (cap_sub),
        .data     (mux_data)
    );

    // Entry payload and tags are only meaningful while an entry is presented.
    always_comb begin
        out_data = '0;
        out_row  = '0;
        out_col  = '0;
        out_last = 1'b0;
        if (out_valid) begin
            out_data = mux_data;
            out_row  = count[IDX_W-1 -: DIM_W];
            out_col  = count[DIM_W-1:0];
            out_last = at_last;
        end
    end

endmodule

// File: tb/tb_mat_result_streamer.sv
// Directed bench for mat_result_streamer: full streams, sign-extension table,
// stalls, ignored re-triggers and asynchronous reset mid-stream.
module tb_mat_result_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic [95:0] mat_in;
    logic        res_valid;
    logic        sub_mode;
    logic [5:0]  out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        done;

    int vec_count   = 0;
    int miscompares = 0;

    logic [5:0] entries  [16];
    logic [5:0] exp_data [16];

    typedef struct {
        logic       sub;
        logic [5:0] e0;
        logic [5:0] e1;
        logic [5:0] x0;
        logic [5:0] x1;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    mat_result_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .mat_in    (mat_in),
        .res_valid (res_valid),
        .sub_mode  (sub_mode),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_count++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [95:0] pack_entries();
        logic [95:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) w[95-6*k -: 6] = entries[k];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Low for one cycle, then a rising edge with the current entries/sub applied.
    task automatic start_stream(input logic sub);
        res_valid = 1'b0;
        tick();
        mat_in    = pack_entries();
        sub_mode  = sub;
        res_valid = 1'b1;
        tick();
        check("latency out_valid", out_valid, 1);
        check("latency busy", busy, 1);
    endtask

    // Collect 16 transfers against exp_data; pat 0 = ready always, 1 = 1,0,0,1.
    task automatic collect(input int pat, input logic inject, input logic [95:0] mat_b);
        int         idx      = 0;
        int         cyc      = 0;
        logic       stalled  = 1'b0;
        logic       raise    = 1'b0;
        logic       injected = 1'b0;
        logic [5:0] pd;
        logic [1:0] pr;
        logic [1:0] pc;
        while (idx < 16 && cyc < 300) begin
            if (raise) begin
                res_valid = 1'b1;
                raise     = 1'b0;
            end
            if (inject && !injected && idx == 5) begin
                res_valid = 1'b0;
                mat_in    = mat_b;
                injected  = 1'b1;
                raise     = 1'b1;
            end
            out_ready = (pat == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (!out_valid) begin
                check("out_valid held until transfer", out_valid, 1);
                cyc = 300;
            end else begin
                if (stalled) begin
                    check("stall data stable", out_data, pd);
                    check("stall row stable", out_row, pr);
                    check("stall col stable", out_col, pc);
                end
                check("busy in stream", busy, 1);
                if (out_ready) begin
                    check("out_data", out_data, exp_data[idx]);
                    check("out_row", out_row, idx / 4);
                    check("out_col", out_col, idx % 4);
                    check("out_last", out_last, (idx == 15));
                    idx++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    pd = out_data;
                    pr = out_row;
                    pc = out_col;
                    check("out_last while stalled", out_last, (idx == 15));
                end
                tick();
                cyc++;
            end
        end
        check("transfer count", idx, 16);
        check("done pulse", done, 1);
        check("valid low in done", out_valid, 0);
        check("busy in done", busy, 1);
        check("last low in done", out_last, 0);
        tick();
        check("done one cycle", done, 0);
        check("busy back to idle", busy, 0);
        check("valid in idle", out_valid, 0);
        out_ready = 1'b1;
    endtask

    initial begin
        vecs[0] = '{sub: 1'b1, e0: 6'b000_111, e1: 6'b000_011, x0: 6'b111_111, x1: 6'b000_011};
        vecs[1] = '{sub: 1'b0, e0: 6'b000_111, e1: 6'b000_011, x0: 6'b000_111, x1: 6'b000_011};
        vecs[2] = '{sub: 1'b1, e0: 6'b101_100, e1: 6'b110_010, x0: 6'b111_100, x1: 6'b000_010};
        vecs[3] = '{sub: 1'b0, e0: 6'b101_100, e1: 6'b110_010, x0: 6'b101_100, x1: 6'b110_010};

        rst       = 1'b0;
        res_valid = 1'b0;
        sub_mode  = 1'b0;
        out_ready = 1'b0;
        mat_in    = '0;
        #2;
        check("reset out_valid", out_valid, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset out_data", out_data, 0);
        check("reset out_last", out_last, 0);
        check("reset out_row", out_row, 0);
        check("reset out_col", out_col, 0);
        repeat (3) @(posedge clk);
        #1;
        rst       = 1'b1;
        out_ready = 1'b1;

        // Basic stream: entry k = k.
        for (int k = 0; k < 16; k++) begin
            entries[k]  = 6'(k);
            exp_data[k] = 6'(k);
        end
        start_stream(1'b0);
        collect(0, 1'b0, '0);

        // Finish level held high: no second stream.
        for (int i = 0; i < 5; i++) begin
            tick();
            check("no restream while held", out_valid, 0);
            check("idle busy while held", busy, 0);
        end

        // Sign-extension table.
        for (int v = 0; v < 4; v++) begin
            for (int k = 0; k < 16; k++) begin
                entries[k]  = '0;
                exp_data[k] = '0;
            end
            entries[0]  = vecs[v].e0;
            entries[1]  = vecs[v].e1;
            exp_data[0] = vecs[v].x0;
            exp_data[1] = vecs[v].x1;
            start_stream(vecs[v].sub);
            collect(0, 1'b0, '0);
        end

        // Stalls with ready pattern 1,0,0,1.
        for (int k = 0; k < 16; k++) begin
            entries[k]  = 6'(63 - k);
            exp_data[k] = 6'(63 - k);
        end
        start_stream(1'b0);
        collect(1, 1'b0, '0);

        // Re-trigger during stream with different data is ignored.
        for (int k = 0; k < 16; k++) entries[k] = 6'(40 + k);
        begin
            logic [95:0] mat_b;
            mat_b = pack_entries();
            for (int k = 0; k < 16; k++) begin
                entries[k]  = 6'(20 + k);
                exp_data[k] = 6'(20 + k);
            end
            start_stream(1'b0);
            collect(0, 1'b1, mat_b);
        end
        tick();
        check("no stream after ignored rise", out_valid, 0);

        // Asynchronous reset at entry 7, then restart from entry 0.
        for (int k = 0; k < 16; k++) begin
            entries[k]  = 6'(10 + k);
            exp_data[k] = 6'(10 + k);
        end
        start_stream(1'b0);
        repeat (7) tick();
        check("entry 7 before reset", out_data, 17);
        check("row before reset", out_row, 1);
        check("col before reset", out_col, 3);
        #2;
        rst = 1'b0;
        #1;
        check("async reset valid", out_valid, 0);
        check("async reset busy", busy, 0);
        check("async reset data", out_data, 0);
        check("async reset done", done, 0);
        tick();
        check("no done in reset", done, 0);
        tick();
        check("no done in reset 2", done, 0);
        rst = 1'b1;
        tick();
        check("restart after reset valid", out_valid, 1);
        collect(0, 1'b0, '0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
